// File: rtl/wfg_wb_decoder.sv
// Registered N-slot Wishbone address decoder and response fabric for the waveform generator.
// One transaction at a time: IDLE accepts, WAIT holds the slave strobe under a watchdog, RESP terminates.
module wfg_wb_decoder #(
    parameter int               BUSW        = 32,
    parameter int               NSLOTS      = 8,
    parameter logic [3:0]       BASE_NIBBLE = 4'h3,
    parameter int               SLOT_SHIFT  = 4,
    parameter int               TIMEOUT     = 16,
    parameter logic [BUSW-1:0]  ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic                     io_wbs_clk,
    input  logic                     io_wbs_rst,
    input  logic [BUSW-1:0]          io_wbs_adr,
    input  logic [BUSW-1:0]          io_wbs_datwr,
    input  logic                     io_wbs_we,
    input  logic                     io_wbs_stb,
    input  logic                     io_wbs_cyc,
    output logic [BUSW-1:0]          io_wbs_datrd,
    output logic                     io_wbs_ack,
    output logic                     io_wbs_err,
    output logic [NSLOTS-1:0]        s_stb_o,
    output logic                     s_cyc_o,
    output logic                     s_we_o,
    output logic [SLOT_SHIFT-1:0]    s_adr_o,
    output logic [BUSW-1:0]          s_dat_o,
    input  logic [NSLOTS*BUSW-1:0]   s_dat_i,
    input  logic [NSLOTS-1:0]        s_ack_i,
    output logic                     busy_o,
    output logic [7:0]               timeout_cnt_o
);

    localparam int              IDXW    = BUSW - 4 - SLOT_SHIFT;
    localparam int              SLW     = $clog2(NSLOTS);
    localparam logic [IDXW-1:0] NSLOT_L = IDXW'(NSLOTS);
    localparam logic [7:0]      WD_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                 state_q, state_d;
    logic [SLW-1:0]         slot_q, slot_d;
    logic [7:0]             wd_q, wd_d;
    logic [NSLOTS-1:0]      stb_q, stb_d;
    logic                   we_q, we_d;
    logic [SLOT_SHIFT-1:0]  adr_q, adr_d;
    logic [BUSW-1:0]        dat_q, dat_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;
    logic [BUSW-1:0]        datrd_q, datrd_d;
    logic [7:0]             tocnt_q, tocnt_d;

    logic [IDXW-1:0]        page_idx;
    logic                   base_hit;
    logic                   page_mapped;
    logic [BUSW-1:0]        s_word [NSLOTS];

    for (genvar k = 0; k < NSLOTS; k++) begin : g_unpack
        assign s_word[k] = s_dat_i[k*BUSW +: BUSW];
    end

    assign page_idx    = io_wbs_adr[BUSW-5:SLOT_SHIFT];
    assign base_hit    = (io_wbs_adr[BUSW-1 -: 4] == BASE_NIBBLE);
    // Page 0 is the null page; anything at or beyond NSLOTS is unmapped.
    assign page_mapped = (page_idx != '0) && (page_idx < NSLOT_L);

    always_comb begin
        state_d = state_q;
        slot_d  = slot_q;
        wd_d    = wd_q;
        stb_d   = stb_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        datrd_d = '0;
        tocnt_d = tocnt_q;

        case (state_q)
            ST_IDLE: begin
                if (io_wbs_cyc && io_wbs_stb && base_hit) begin
                    slot_d = page_idx[SLW-1:0];
                    we_d   = io_wbs_we;
                    adr_d  = io_wbs_adr[SLOT_SHIFT-1:0];
                    dat_d  = io_wbs_datwr;
                    if (page_mapped) begin
                        state_d                  = ST_WAIT;
                        wd_d                     = '0;
                        stb_d                    = '0;
                        stb_d[page_idx[SLW-1:0]] = 1'b1;
                    end else begin
                        state_d = ST_RESP;
                        err_d   = 1'b1;
                        datrd_d = ERR_DATA;
                    end
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + 8'd1;
                // Abort beats everything else: the master has already walked away.
                if (!io_wbs_cyc) begin
                    state_d = ST_IDLE;
                    stb_d   = '0;
                    we_d    = 1'b0;
                    adr_d   = '0;
                    dat_d   = '0;
                end else if (s_ack_i[slot_q]) begin
                    state_d = ST_RESP;
                    stb_d   = '0;
                    ack_d   = 1'b1;
                    datrd_d = s_word[slot_q];
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_RESP;
                    stb_d   = '0;
                    err_d   = 1'b1;
                    datrd_d = ERR_DATA;
                    if (tocnt_q != 8'hFF) begin
                        tocnt_d = tocnt_q + 8'd1;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                stb_d   = '0;
            end
        endcase
    end

    always_ff @(posedge io_wbs_clk) begin
        if (io_wbs_rst) begin
            state_q <= ST_IDLE;
            slot_q  <= '0;
            wd_q    <= '0;
            stb_q   <= '0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            datrd_q <= '0;
            tocnt_q <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            wd_q    <= wd_d;
            stb_q   <= stb_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            datrd_q <= datrd_d;
            tocnt_q <= tocnt_d;
        end
    end

    assign io_wbs_datrd  = datrd_q;
    assign io_wbs_ack    = ack_q;
    assign io_wbs_err    = err_q;
    assign s_stb_o       = stb_q;
    assign s_cyc_o       = (state_q == ST_WAIT);
    assign s_we_o        = we_q;
    assign s_adr_o       = adr_q;
    assign s_dat_o       = dat_q;
    assign busy_o        = (state_q != ST_IDLE);
    assign timeout_cnt_o = tocnt_q;

endmodule
